// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide, byte-masked RAM port. Handles byte/half/word
// requests at any alignment, splitting word-straddling accesses into two RAM transactions.
module mem_access_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_address,
    input  logic [31:0] i_req_write_data,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_data,
    output logic        o_resp_error,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_write,
    output logic [3:0]  o_byte_mask,
    input  logic [31:0] i_mem_read_data
);

    typedef enum logic [2:0] {
        StIdle, StSt0, StSt1, StLd0, StLd1, StLdw, StResp, StErr
    } state_t;

    state_t      r_state;
    logic        r_straddle;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_word1;
    logic [31:0] r_hi_data;
    logic [3:0]  r_hi_mask;
    logic [31:0] r_lo;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_error;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_write_data;
    logic        r_mem_write;
    logic [3:0]  r_byte_mask;

    logic [1:0]  w_off;
    logic [3:0]  w_size_mask;
    logic [7:0]  w_m8;
    logic [63:0] w_d64;
    logic        w_straddle;
    logic        w_err;
    logic [31:0] w_word0;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic [31:0] w_raw;
    logic [31:0] w_load;

    assign w_off      = i_req_address[1:0];
    assign w_m8       = {4'b0000, w_size_mask} << w_off;
    assign w_d64      = {32'h0, i_req_write_data} << {w_off, 3'b000};
    assign w_straddle = |w_m8[7:4];
    assign w_err      = (i_req_size == 2'b11) || (!SPLIT_MISALIGNED && w_straddle);
    assign w_word0    = {i_req_address[31:2], 2'b00};

    always_comb begin
        w_size_mask = 4'b0000;
        case (i_req_size)
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            2'b10:   w_size_mask = 4'b1111;
            default: w_size_mask = 4'b0000;
        endcase
    end

    // The final read beat is the high word only for split loads.
    assign w_lo  = r_straddle ? r_lo : i_mem_read_data;
    assign w_hi  = r_straddle ? i_mem_read_data : 32'h0;
    assign w_raw = 32'({w_hi, w_lo} >> {r_off, 3'b000});

    always_comb begin
        w_load = w_raw;
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'h0, w_raw[7:0]} : {{24{w_raw[7]}}, w_raw[7:0]};
            2'b01:   w_load = r_unsigned ? {16'h0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
            default: w_load = w_raw;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state          <= StIdle;
            r_straddle       <= 1'b0;
            r_off            <= 2'b00;
            r_size           <= 2'b00;
            r_unsigned       <= 1'b0;
            r_word1          <= 32'h0;
            r_hi_data        <= 32'h0;
            r_hi_mask        <= 4'b0000;
            r_lo             <= 32'h0;
            r_req_ready      <= 1'b1;
            r_resp_valid     <= 1'b0;
            r_resp_data      <= 32'h0;
            r_resp_error     <= 1'b0;
            r_mem_address    <= 32'h0;
            r_mem_write_data <= 32'h0;
            r_mem_write      <= 1'b0;
            r_byte_mask      <= 4'b0000;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_straddle  <= w_straddle;
                        r_off       <= w_off;
                        r_size      <= i_req_size;
                        r_unsigned  <= i_req_unsigned;
                        r_word1     <= w_word0 + 32'd4;
                        r_hi_data   <= w_d64[63:32];
                        r_hi_mask   <= w_m8[7:4];
                        if (w_err) begin
                            r_state <= StErr;
                        end else if (i_req_write) begin
                            r_mem_address    <= w_word0;
                            r_mem_write_data <= w_d64[31:0];
                            r_byte_mask      <= w_m8[3:0];
                            r_mem_write      <= 1'b1;
                            r_state          <= StSt0;
                        end else begin
                            r_mem_address <= w_word0;
                            r_state       <= StLd0;
                        end
                    end
                end
                // Errors idle one cycle so every response lands at least two cycles after accept.
                StErr: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b1;
                    r_resp_data  <= 32'h0;
                    r_state      <= StResp;
                end
                StSt0: begin
                    if (r_straddle) begin
                        r_mem_address    <= r_word1;
                        r_mem_write_data <= r_hi_data;
                        r_byte_mask      <= r_hi_mask;
                        r_state          <= StSt1;
                    end else begin
                        r_mem_write  <= 1'b0;
                        r_byte_mask  <= 4'b0000;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b0;
                        r_resp_data  <= 32'h0;
                        r_state      <= StResp;
                    end
                end
                StSt1: begin
                    r_mem_write  <= 1'b0;
                    r_byte_mask  <= 4'b0000;
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= 32'h0;
                    r_state      <= StResp;
                end
                StLd0: begin
                    if (r_straddle) begin
                        r_mem_address <= r_word1;
                        r_state       <= StLd1;
                    end else begin
                        r_state <= StLdw;
                    end
                end
                StLd1: begin
                    r_lo    <= i_mem_read_data;
                    r_state <= StLdw;
                end
                StLdw: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= w_load;
                    r_state      <= StResp;
                end
                StResp: begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready      = r_req_ready;
    assign o_resp_valid     = r_resp_valid;
    assign o_resp_data      = r_resp_data;
    assign o_resp_error     = r_resp_error;
    assign o_mem_address    = r_mem_address;
    assign o_mem_write_data = r_mem_write_data;
    assign o_mem_write      = r_mem_write;
    assign o_byte_mask      = r_byte_mask;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, split/no-split error cases, reset during
// a split store, and random traffic checked against a byte-addressed memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic [31:0] rdata;

    logic        a_ready, a_rv, a_re, a_mw;
    logic [31:0] a_rd, a_ma, a_mwd;
    logic [3:0]  a_bm;
    logic        b_ready, b_rv, b_re, b_mw;
    logic [31:0] b_rd, b_ma, b_mwd;
    logic [3:0]  b_bm;

    logic        w_ready, w_rv, w_re, w_mw;
    logic [31:0] w_rd, w_ma, w_mwd;
    logic [3:0]  w_bm;

    int n_cmp;
    int n_fail;

    logic [31:0] ram [0:16383];
    logic [7:0]  ref_mem [0:65535];

    int          ntx;
    logic [31:0] tx_addr [4];
    logic [3:0]  tx_mask [4];
    logic [31:0] tx_data [4];

    mem_access_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid & ~sel), .o_req_ready(a_ready),
        .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_address(req_address), .i_req_write_data(req_wdata),
        .o_resp_valid(a_rv), .o_resp_data(a_rd), .o_resp_error(a_re),
        .o_mem_address(a_ma), .o_mem_write_data(a_mwd), .o_mem_write(a_mw),
        .o_byte_mask(a_bm), .i_mem_read_data(rdata)
    );

    mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid & sel), .o_req_ready(b_ready),
        .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_address(req_address), .i_req_write_data(req_wdata),
        .o_resp_valid(b_rv), .o_resp_data(b_rd), .o_resp_error(b_re),
        .o_mem_address(b_ma), .o_mem_write_data(b_mwd), .o_mem_write(b_mw),
        .o_byte_mask(b_bm), .i_mem_read_data(32'h0)
    );

    assign w_ready = sel ? b_ready : a_ready;
    assign w_rv    = sel ? b_rv : a_rv;
    assign w_rd    = sel ? b_rd : a_rd;
    assign w_re    = sel ? b_re : a_re;
    assign w_mw    = sel ? b_mw : a_mw;
    assign w_ma    = sel ? b_ma : a_ma;
    assign w_mwd   = sel ? b_mwd : a_mwd;
    assign w_bm    = sel ? b_bm : a_bm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM with one-cycle registered read, driven by the split-capable unit.
    always @(posedge clk) begin
        logic [31:0] word;
        rdata <= ram[a_ma[15:2]];
        if (a_mw) begin
            word = ram[a_ma[15:2]];
            for (int i = 0; i < 4; i++)
                if (a_bm[i]) word[8*i +: 8] = a_mwd[8*i +: 8];
            ram[a_ma[15:2]] <= word;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request; returns cycles from accept to respValid (0 on timeout).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic re);
        int k;
        k = 0;
        while (!w_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_before_req", {31'h0, w_ready}, 32'h1);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_address  = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ntx = 0;
        lat = 0;
        rd  = 32'hx;
        re  = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            if (w_mw) begin
                if (ntx < 4) begin
                    tx_addr[ntx] = w_ma;
                    tx_mask[ntx] = w_bm;
                    tx_data[ntx] = w_mwd;
                end
                ntx++;
            end
            if (w_rv) begin
                lat = c;
                rd  = w_rd;
                re  = w_re;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic        err;
        logic [31:0] data;
        int          ntx;
        logic [31:0] a0;
        logic [3:0]  m0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  m1;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs [19];

    task automatic run_vec(input vec_t v, input string tag);
        int          lat;
        logic [31:0] rd;
        logic        re;
        do_req(v.w, v.sz, v.u, v.a, v.d, lat, rd, re);
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_error"}, {31'h0, re}, {31'h0, v.err});
        check({tag, "_data"}, rd, v.data);
        check({tag, "_ntx"}, ntx, v.ntx);
        if (v.ntx >= 1 && ntx >= 1) begin
            check({tag, "_tx0_addr"}, tx_addr[0], v.a0);
            check({tag, "_tx0_mask"}, {28'h0, tx_mask[0]}, {28'h0, v.m0});
            check({tag, "_tx0_data"}, tx_data[0], v.d0);
        end
        if (v.ntx >= 2 && ntx >= 2) begin
            check({tag, "_tx1_addr"}, tx_addr[1], v.a1);
            check({tag, "_tx1_mask"}, {28'h0, tx_mask[1]}, {28'h0, v.m1});
            check({tag, "_tx1_data"}, tx_data[1], v.d1);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        re;
        vec_t        v;

        n_cmp = 0;
        n_fail = 0;
        sel = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_address = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h0;

        // w sz u addr data | lat err data ntx | a0 m0 d0 | a1 m1 d1
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1,
                     32'h0, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_8003, 32'h12345678, 2, 1'b0, 32'h0, 1,
                     32'h8000, 4'h8, 32'h78000000, 32'h0, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_8003, 32'h0, 3, 1'b0, 32'h00000078, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_8003, 32'h0, 3, 1'b0, 32'h00000078, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h0000_8003, 32'h00000080, 2, 1'b0, 32'h0, 1,
                     32'h8000, 4'h8, 32'h80000000, 32'h0, 4'h0, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0000_8003, 32'h0, 3, 1'b0, 32'hFFFFFF80, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_8003, 32'h0, 3, 1'b0, 32'h00000080, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_4002, 32'hAABBCCDD, 3, 1'b0, 32'h0, 2,
                     32'h4000, 4'hC, 32'hCCDD0000, 32'h4004, 4'h3, 32'h0000AABB};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 4, 1'b0, 32'hAABBCCDD, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000BEEF, 3, 1'b0, 32'h0, 2,
                     32'hFFFFFFFC, 4'h8, 32'hEF000000, 32'h0, 4'h1, 32'h000000BE};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 4, 1'b0, 32'h0000BEEF, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[12] = '{1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4, 1'b0, 32'hFFFFBEEF, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[13] = '{1'b1, 2'd3, 1'b0, 32'h0000_0010, 32'h11223344, 2, 1'b1, 32'h0, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[14] = '{1'b0, 2'd3, 1'b1, 32'h0000_0010, 32'h0, 2, 1'b1, 32'h0, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 3, 1'b0, 32'hDEADBEBE, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[16] = '{1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'hFFFF1234, 2, 1'b0, 32'h0, 1,
                     32'h0, 4'hC, 32'h12340000, 32'h0, 4'h0, 32'h0};
        vecs[17] = '{1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 3, 1'b0, 32'h00001234, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[18] = '{1'b0, 2'd2, 1'b1, 32'h0000_0000, 32'h0, 3, 1'b0, 32'h1234BEBE, 0,
                     32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, a_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, a_rv}, 32'h0);
        check("rst_resp_data", a_rd, 32'h0);
        check("rst_resp_error", {31'h0, a_re}, 32'h0);
        check("rst_mem_address", a_ma, 32'h0);
        check("rst_mem_wdata", a_mwd, 32'h0);
        check("rst_mem_write", {31'h0, a_mw}, 32'h0);
        check("rst_byte_mask", {28'h0, a_bm}, 32'h0);
        check("rst_ns_ready", {31'h0, b_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Straddles are rejected without RAM traffic when splitting is disabled.
        sel = 1'b1;
        v = '{1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 2, 1'b1, 32'h0, 0,
              32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        run_vec(v, "ns_lw_straddle");
        v = '{1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'h5555, 2, 1'b1, 32'h0, 0,
              32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
        run_vec(v, "ns_sh_straddle");
        sel = 1'b0;
        @(posedge clk); #1;

        // Reset while the second half of a split store is on the bus.
        req_write = 1'b1;
        req_size = 2'd2;
        req_unsigned = 1'b0;
        req_address = 32'h0000_5002;
        req_wdata = 32'h01020304;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst6_st0_write", {31'h0, a_mw}, 32'h1);
        check("rst6_st0_addr", a_ma, 32'h5000);
        @(posedge clk); #1;
        check("rst6_st1_write", {31'h0, a_mw}, 32'h1);
        check("rst6_st1_addr", a_ma, 32'h5004);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst6_write_drop", {31'h0, a_mw}, 32'h0);
        check("rst6_mask_drop", {28'h0, a_bm}, 32'h0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (a_rv) seen++;
            end
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                if (a_rv) seen++;
            end
            check("rst6_no_resp", seen, 0);
        end
        check("rst6_ready", {31'h0, a_ready}, 32'h1);
        run_vec(vecs[0], "rst6_sw");
        run_vec(vecs[1], "rst6_lw");

        // Random traffic in a private window, checked against a byte-level memory model.
        for (int n = 0; n < 250; n++) begin
            logic        w, u, strad, err;
            logic [1:0]  sz;
            logic [31:0] a, d, exp_v;
            int          nb, off, exp_lat, exp_ntx;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'h200 + 32'($urandom_range(0, 31));
            d  = $urandom;
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            off = int'(a % 4);
            err = (sz == 2'd3);
            strad = !err && (off + nb > 4);
            exp_v = 32'h0;
            if (err) begin
                exp_lat = 2;
                exp_ntx = 0;
            end else if (w) begin
                exp_lat = strad ? 3 : 2;
                exp_ntx = strad ? 2 : 1;
                for (int i = 0; i < nb; i++) ref_mem[16'(a + 32'(i))] = d[8*i +: 8];
            end else begin
                exp_lat = strad ? 4 : 3;
                exp_ntx = 0;
                for (int i = 0; i < nb; i++) exp_v[8*i +: 8] = ref_mem[16'(a + 32'(i))];
                if (nb == 1 && !u && exp_v[7]) exp_v = exp_v | 32'hFFFFFF00;
                if (nb == 2 && !u && exp_v[15]) exp_v = exp_v | 32'hFFFF0000;
            end
            do_req(w, sz, u, a, d, lat, rd, re);
            check($sformatf("rnd%0d_latency", n), lat, exp_lat);
            check($sformatf("rnd%0d_error", n), {31'h0, re}, {31'h0, err});
            check($sformatf("rnd%0d_data", n), rd, exp_v);
            check($sformatf("rnd%0d_ntx", n), ntx, exp_ntx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
